// File: rtl/sfp_tx_arbiter.sv
// sfp_tx_arbiter: arbitrates four frame sources onto one SFP transmitter, one frame in flight
module sfp_tx_arbiter #(
    parameter int C_DATA_FRAME_BIT = 128,
    parameter int C_TIMEOUT        = 1000,
    parameter int C_GAP            = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [3:0]                  i_req,
    input  logic [C_DATA_FRAME_BIT-1:0] i_frame_0,
    input  logic [C_DATA_FRAME_BIT-1:0] i_frame_1,
    input  logic [C_DATA_FRAME_BIT-1:0] i_frame_2,
    input  logic [C_DATA_FRAME_BIT-1:0] i_frame_3,
    output logic [3:0]                  o_ack,
    output logic [1:0]                  o_grant_id,
    output logic [C_DATA_FRAME_BIT-1:0] o_tx_data,
    output logic                        o_tx_start,
    input  logic                        i_tx_done,
    output logic                        o_busy,
    output logic                        o_timeout,
    input  logic                        i_timeout_clr,
    output logic [15:0]                 o_tx_cnt
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP} state_t;
    state_t state;
    logic [1:0] rr_ptr, c1, c2, c3, pick;
    logic [15:0] wait_cnt, gap_cnt;
    logic [C_DATA_FRAME_BIT-1:0] frames [4];
    assign frames[0] = i_frame_0;
    assign frames[1] = i_frame_1;
    assign frames[2] = i_frame_2;
    assign frames[3] = i_frame_3;
    assign o_busy = state != IDLE;
    // winner: pass-through always, else rotate over 1..3 starting after the last served
    always_comb begin
        c1 = (rr_ptr == 2'd3) ? 2'd1 : rr_ptr + 2'd1;
        c2 = (c1 == 2'd3) ? 2'd1 : c1 + 2'd1;
        c3 = (c2 == 2'd3) ? 2'd1 : c2 + 2'd1;
        pick = i_req[0] ? 2'd0 : i_req[c1] ? c1 : i_req[c2] ? c2 : c3;
    end
    // frame sequencer with registered handshake outputs; a late timeout set overrides a clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            rr_ptr     <= 2'd3;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            o_ack      <= '0;
            o_grant_id <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            o_tx_cnt   <= '0;
        end else begin
            o_ack      <= '0;
            o_tx_start <= 1'b0;
            if (i_timeout_clr) o_timeout <= 1'b0;
            case (state)
                IDLE: if (|i_req) begin
                    o_grant_id <= pick;
                    state      <= LOAD;
                end
                LOAD: if (i_req[o_grant_id]) begin
                    o_tx_data         <= frames[o_grant_id];
                    o_ack[o_grant_id] <= 1'b1;
                    if (o_grant_id != 2'd0) rr_ptr <= o_grant_id;
                    state             <= START;
                end else begin
                    state <= IDLE;
                end
                START: begin
                    o_tx_start <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= WAIT;
                end
                WAIT: if (i_tx_done) begin
                    o_tx_cnt <= o_tx_cnt + 16'd1;
                    gap_cnt  <= '0;
                    state    <= GAP;
                end else if (wait_cnt == 16'(C_TIMEOUT - 1)) begin
                    o_timeout <= 1'b1;
                    gap_cnt   <= '0;
                    state     <= GAP;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                GAP: if (gap_cnt == 16'(C_GAP - 1)) state <= IDLE;
                     else gap_cnt <= gap_cnt + 16'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sfp_tx_arbiter.sv
// tb_sfp_tx_arbiter: directed checks of arbitration, latency, abort, timeout, wrap and reset
module tb_sfp_tx_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] frm [4];
    logic [3:0]   ack;
    logic [1:0]   grant_id;
    logic [127:0] tx_data;
    logic         tx_start;
    logic         tx_done = 1'b0;
    logic         busy;
    logic         timeout;
    logic         timeout_clr = 1'b0;
    logic [15:0]  tx_cnt;
    int n_tests = 0;
    int n_fail = 0;
    int overlap = 0;

    sfp_tx_arbiter #(.C_DATA_FRAME_BIT(128), .C_TIMEOUT(8), .C_GAP(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_frame_0(frm[0]), .i_frame_1(frm[1]), .i_frame_2(frm[2]), .i_frame_3(frm[3]),
        .o_ack(ack), .o_grant_id(grant_id), .o_tx_data(tx_data), .o_tx_start(tx_start),
        .i_tx_done(tx_done), .o_busy(busy), .o_timeout(timeout),
        .i_timeout_clr(timeout_clr), .o_tx_cnt(tx_cnt)
    );

    always #5 clk = ~clk;

    // ack and start must never coincide
    always @(negedge clk) if (!rst && ack != 4'd0 && tx_start) overlap++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int t = 0;
        while (ack == 4'd0 && t < 20) begin
            step();
            t++;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 40) begin
            step();
            t++;
        end
        check("idle", busy, 0);
    endtask

    task automatic frame(input logic [1:0] exp_gid, input int dly);
        wait_ack();
        check("ack_pulse", ack, 4'b1 << exp_gid);
        check("grant_id", grant_id, exp_gid);
        check("tx_data", tx_data, frm[exp_gid]);
        check("start_not_with_ack", tx_start, 0);
        step();
        check("tx_start", tx_start, 1);
        repeat (dly) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    initial begin
        frm[0] = {32{4'hA}};
        frm[1] = {8{16'h1111}};
        frm[2] = {8{16'h2222}};
        frm[3] = {8{16'h3333}};
        step();
        step();
        check("rst_ack", ack, 0);
        check("rst_grant", grant_id, 0);
        check("rst_data", tx_data, 0);
        check("rst_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cnt", tx_cnt, 0);
        rst = 1'b0;
        // round robin 1,2,3,1 with done five cycles after each start
        req = 4'b1110;
        frame(2'd1, 4);
        frame(2'd2, 4);
        frame(2'd3, 4);
        frame(2'd1, 4);
        req = 4'b0000;
        check("rr_cnt4", tx_cnt, 4);
        wait_idle();
        // pass-through priority and three-cycle request-to-start latency
        req = 4'b0101;
        step();
        check("lat_load_ack", ack, 0);
        check("lat_load_busy", busy, 1);
        check("pt_grant", grant_id, 0);
        step();
        check("pt_ack", ack, 4'b0001);
        check("pt_data", tx_data, {32{4'hA}});
        check("pt_start_early", tx_start, 0);
        step();
        check("pt_start", tx_start, 1);
        check("pt_ack_cleared", ack, 0);
        req = 4'b0000;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("pt_cnt", tx_cnt, 5);
        wait_idle();
        // single-cycle request aborts in LOAD
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        check("abort_ack", ack, 0);
        check("abort_idle", busy, 0);
        check("abort_grant", grant_id, 2);
        check("abort_data_held", tx_data, {32{4'hA}});
        repeat (2) begin
            step();
            check("abort_no_start", tx_start, 0);
        end
        req = 4'b1110;
        frame(2'd2, 4);
        req = 4'b0000;
        check("abort_cnt", tx_cnt, 6);
        wait_idle();
        // timeout after eight WAIT cycles
        req = 4'b0010;
        wait_ack();
        check("to_grant", grant_id, 1);
        req = 4'b0000;
        step();
        check("to_start", tx_start, 1);
        repeat (7) step();
        check("to_not_yet", timeout, 0);
        check("to_still_wait", busy, 1);
        step();
        check("to_set", timeout, 1);
        check("to_cnt_hold", tx_cnt, 6);
        wait_idle();
        req = 4'b0010;
        frame(2'd1, 4);
        req = 4'b0000;
        check("to_next_served", tx_cnt, 7);
        check("to_sticky", timeout, 1);
        wait_idle();
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        check("to_clr", timeout, 0);
        // counter wrap from 0xFFFF
        force dut.o_tx_cnt = 16'hFFFF;
        step();
        release dut.o_tx_cnt;
        req = 4'b1000;
        frame(2'd3, 2);
        req = 4'b0000;
        check("wrap_cnt", tx_cnt, 16'h0000);
        wait_idle();
        req = 4'b0010;
        frame(2'd1, 2);
        req = 4'b0000;
        check("wrap_next", tx_cnt, 16'h0001);
        wait_idle();
        // reset during WAIT
        req = 4'b0100;
        wait_ack();
        check("rw_grant", grant_id, 2);
        req = 4'b0000;
        step();
        step();
        check("rw_in_wait", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rw_ack", ack, 0);
        check("rw_grant_rst", grant_id, 0);
        check("rw_data", tx_data, 0);
        check("rw_start", tx_start, 0);
        check("rw_busy", busy, 0);
        check("rw_cnt", tx_cnt, 0);
        repeat (3) begin
            step();
            check("rw_no_pending", {ack, tx_start}, 0);
        end
        req = 4'b1110;
        frame(2'd1, 2);
        req = 4'b0000;
        check("rw_first_cnt", tx_cnt, 1);
        wait_idle();
        check("ack_start_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
